// File: rtl/sha_mem_responder_if.sv
// Bus bundle for sha_mem_responder: initiator word port, preload stream and digest results.
interface sha_mem_responder_if;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_write_data;
  logic [31:0]  mem_read_data;
  logic         load_start;
  logic [15:0]  load_base;
  logic         load_valid;
  logic         load_last;
  logic [31:0]  load_data;
  logic         load_ready;
  logic [255:0] hash_out;
  logic         hash_valid;
  logic [15:0]  write_count;
  logic         addr_err;

  modport master (
    output mem_we, mem_addr, mem_write_data, load_start, load_base,
           load_valid, load_last, load_data,
    input  mem_read_data, load_ready, hash_out, hash_valid, write_count, addr_err
  );

  modport slave (
    input  mem_we, mem_addr, mem_write_data, load_start, load_base,
           load_valid, load_last, load_data,
    output mem_read_data, load_ready, hash_out, hash_valid, write_count, addr_err
  );
endinterface

// File: rtl/sha_mem_responder.sv
// Word memory serving a hash core, with a preload stream and an 8-word digest capture window.
// Optional macro MEM_ADDR_CHECK_EN: out-of-range addresses are rejected and flagged on addr_err.
module sha_mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter logic [15:0] OUTPUT_ADDR = 16'h0080
) (
  input logic                clk,
  input logic                reset_n,
  sha_mem_responder_if.slave bus
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [15:0] LAST_IDX = 16'(DEPTH - 1);

  typedef enum logic {SERVE = 1'b0, LOAD = 1'b1} state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic [31:0]    mem_r [DEPTH];
  logic [31:0]    mem_read_data_r;
  logic [255:0]   hash_out_r;
  logic           hash_valid_r;
  logic [15:0]    write_count_r;
  logic           addr_err_r;
  logic [7:0]     mask_r;
  logic [15:0]    load_ptr_r;
  logic           load_ready_r;

  logic           addr_ok_s;
  logic           ptr_ok_s;
  logic           serve_s;
  logic           beat_s;
  logic           start_s;
  logic           serve_wr_s;
  logic           serve_rd_s;
  logic           mem_wr_en_s;
  logic [AW-1:0]  mem_wr_idx_s;
  logic [31:0]    mem_wr_data_s;
  logic           cap_hit_s;
  logic [2:0]     cap_slot_s;
  logic [7:0]     mask_next_s;
  logic           cap_done_s;
  logic           err_set_s;
  logic [15:0]    ptr_next_s;

`ifdef MEM_ADDR_CHECK_EN
  assign addr_ok_s = ~|bus.mem_addr[15:AW];
  assign ptr_ok_s  = ~|load_ptr_r[15:AW];
`else
  assign addr_ok_s = 1'b1;
  assign ptr_ok_s  = 1'b1;
`endif

  // Next state, array write port selection and digest mask update.
  always_comb begin
    state_next_s  = state_r;
    serve_s       = (state_r == SERVE);
    beat_s        = (state_r == LOAD) && bus.load_valid;
    start_s       = serve_s && bus.load_start;
    serve_wr_s    = serve_s && bus.mem_we;
    serve_rd_s    = serve_s && !bus.mem_we;
    mem_wr_en_s   = 1'b0;
    mem_wr_idx_s  = {AW{1'b0}};
    mem_wr_data_s = 32'h0000_0000;
    err_set_s     = (beat_s && !ptr_ok_s) || (serve_s && !addr_ok_s);
    ptr_next_s    = (load_ptr_r == LAST_IDX) ? 16'h0000 : (load_ptr_r + 16'd1);

    case (state_r)
      SERVE: begin
        if (bus.load_start) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = SERVE;
        end
      end
      LOAD: begin
        if (bus.load_valid && bus.load_last) begin
          state_next_s = SERVE;
        end else begin
          state_next_s = LOAD;
        end
      end
      default: state_next_s = SERVE;
    endcase

    if (beat_s) begin
      mem_wr_en_s   = ptr_ok_s;
      mem_wr_idx_s  = load_ptr_r[AW-1:0];
      mem_wr_data_s = bus.load_data;
    end else if (serve_wr_s) begin
      mem_wr_en_s   = addr_ok_s;
      mem_wr_idx_s  = bus.mem_addr[AW-1:0];
      mem_wr_data_s = bus.mem_write_data;
    end else begin
      mem_wr_en_s   = 1'b0;
    end

    // 17-bit compare keeps the window test correct when OUTPUT_ADDR sits near the top of the map.
    cap_hit_s   = serve_wr_s && addr_ok_s && (bus.mem_addr >= OUTPUT_ADDR) &&
                  ({1'b0, bus.mem_addr} <= ({1'b0, OUTPUT_ADDR} + 17'd7));
    cap_slot_s  = 3'(bus.mem_addr - OUTPUT_ADDR);
    mask_next_s = start_s ? 8'h00 : mask_r;
    if (cap_hit_s) begin
      mask_next_s = mask_next_s | (8'h01 << cap_slot_s);
    end else begin
      mask_next_s = mask_next_s;
    end
    cap_done_s  = (mask_next_s == 8'hFF);
  end

  // Control, read data, counters and digest registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= SERVE;
      load_ready_r    <= 1'b0;
      load_ptr_r      <= 16'h0000;
      mem_read_data_r <= 32'h0000_0000;
      write_count_r   <= 16'h0000;
      hash_out_r      <= 256'h0;
      mask_r          <= 8'h00;
      hash_valid_r    <= 1'b0;
      addr_err_r      <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      load_ready_r <= (state_next_s == LOAD);
      if (start_s) begin
        load_ptr_r <= bus.load_base;
      end else if (beat_s) begin
        load_ptr_r <= ptr_next_s;
      end
      if (serve_rd_s) begin
        mem_read_data_r <= addr_ok_s ? mem_r[bus.mem_addr[AW-1:0]] : 32'hDEAD_BEEF;
      end
      if (serve_wr_s && addr_ok_s && (write_count_r != 16'hFFFF)) begin
        write_count_r <= write_count_r + 16'd1;
      end
      if (cap_hit_s) begin
        hash_out_r[{3'd7 - cap_slot_s, 5'd0} +: 32] <= bus.mem_write_data;
      end
      mask_r       <= cap_done_s ? 8'h00 : mask_next_s;
      hash_valid_r <= cap_done_s;
      // A fresh error in the same cycle as load_start wins over the clear.
      if (err_set_s) begin
        addr_err_r <= 1'b1;
      end else if (start_s) begin
        addr_err_r <= 1'b0;
      end
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_wr_en_s) begin
      mem_r[mem_wr_idx_s] <= mem_wr_data_s;
    end
  end

  assign bus.mem_read_data = mem_read_data_r;
  assign bus.load_ready    = load_ready_r;
  assign bus.hash_out      = hash_out_r;
  assign bus.hash_valid    = hash_valid_r;
  assign bus.write_count   = write_count_r;
  assign bus.addr_err      = addr_err_r;
endmodule

// File: tb/tb_sha_mem_responder.sv
// Self-checking bench for sha_mem_responder: vector table, directed corner sequences
// and randomized traffic against a reference model of the memory/digest behaviour.
module tb_sha_mem_responder;
  localparam int DEPTH    = 256;
  localparam int OUT_ADDR = 'h80;
`ifdef MEM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  sha_mem_responder_if bus();

  sha_mem_responder #(.DEPTH(DEPTH), .OUTPUT_ADDR(16'h0080)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  bit          m_load;
  int          m_ptr;
  logic [31:0] m_rd;
  bit          m_rd_known;
  logic [31:0] m_hash [8];
  bit   [7:0]  m_cap;
  bit          m_hv;
  int          m_cnt;
  bit          m_err;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        exp_hv;
    logic [15:0] exp_cnt;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] model_hash();
    logic [255:0] h;
    h = 256'h0;
    for (int k = 0; k < 8; k++) h[255 - 32*k -: 32] = m_hash[k];
    return h;
  endfunction

  task automatic model_reset();
    m_load = 1'b0; m_ptr = 0; m_rd = 32'h0; m_rd_known = 1'b1;
    m_cap = 8'h00; m_hv = 1'b0; m_cnt = 0; m_err = 1'b0;
    for (int k = 0; k < 8; k++) m_hash[k] = 32'h0;
    for (int k = 0; k < DEPTH; k++) m_known[k] = 1'b0;
  endtask

  task automatic model_step();
    int a;
    bit ok;
    m_hv = 1'b0;
    if (!m_load) begin
      a  = int'(bus.mem_addr) % DEPTH;
      ok = !CHK || (int'(bus.mem_addr) < DEPTH);
      if (bus.mem_we) begin
        if (ok) begin
          m_mem[a] = bus.mem_write_data;
          m_known[a] = 1'b1;
          if (m_cnt < 65535) m_cnt++;
        end
      end else begin
        m_rd = ok ? m_mem[a] : 32'hDEADBEEF;
        m_rd_known = !ok || m_known[a];
      end
      if (bus.load_start) begin
        m_err = 1'b0; m_cap = 8'h00; m_load = 1'b1; m_ptr = int'(bus.load_base);
      end
      if (!ok) m_err = 1'b1;
      if (bus.mem_we && ok && int'(bus.mem_addr) >= OUT_ADDR && int'(bus.mem_addr) < OUT_ADDR + 8) begin
        m_hash[int'(bus.mem_addr) - OUT_ADDR] = bus.mem_write_data;
        m_cap[int'(bus.mem_addr) - OUT_ADDR] = 1'b1;
      end
      if (m_cap == 8'hFF) begin
        m_hv = 1'b1; m_cap = 8'h00;
      end
    end else if (bus.load_valid) begin
      ok = !CHK || (m_ptr < DEPTH);
      if (ok) begin
        m_mem[m_ptr % DEPTH] = bus.load_data;
        m_known[m_ptr % DEPTH] = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      m_ptr = (m_ptr < DEPTH) ? (m_ptr + 1) % DEPTH : (m_ptr + 1) & 'hFFFF;
      if (bus.load_last) m_load = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("load_ready", 256'(bus.load_ready), 256'(m_load));
    check("hash_valid", 256'(bus.hash_valid), 256'(m_hv));
    check("write_count", 256'(bus.write_count), 256'(m_cnt));
    check("addr_err", 256'(bus.addr_err), 256'(m_err));
    check("hash_out", bus.hash_out, model_hash());
    if (m_rd_known) check("read_data", 256'(bus.mem_read_data), 256'(m_rd));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    bus.mem_we = 1'b0; bus.mem_addr = 16'h0000; bus.mem_write_data = 32'h0;
    bus.load_start = 1'b0; bus.load_base = 16'h0000; bus.load_valid = 1'b0;
    bus.load_last = 1'b0; bus.load_data = 32'h0;
  endtask

  task automatic write_word(input logic [15:0] addr, input logic [31:0] data);
    idle(); bus.mem_we = 1'b1; bus.mem_addr = addr; bus.mem_write_data = data;
    cycle();
  endtask

  task automatic read_word(input logic [15:0] addr);
    idle(); bus.mem_addr = addr;
    cycle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    check("rst_read_data", 256'(bus.mem_read_data), 256'h0);
    check("rst_hash_out", bus.hash_out, 256'h0);
    check("rst_hash_valid", 256'(bus.hash_valid), 256'h0);
    check("rst_write_count", 256'(bus.write_count), 256'h0);
    check("rst_addr_err", 256'(bus.addr_err), 256'h0);
    check("rst_load_ready", 256'(bus.load_ready), 256'h0);
    @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    idle();
    model_reset();
    do_reset();

    // Full digest from a vector table
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 16'h0080 + 16'(i), 32'h11111111 * 32'(i + 1), (i == 7), 16'(i + 1), 1'b0, 32'h0};
    tbl[8] = '{1'b0, 16'h0083, 32'h0, 1'b0, 16'd8, 1'b1, 32'h44444444};
    tbl[9] = '{1'b0, 16'h0087, 32'h0, 1'b0, 16'd8, 1'b1, 32'h88888888};
    for (int i = 0; i < 10; i++) begin
      idle();
      bus.mem_we = tbl[i].we; bus.mem_addr = tbl[i].addr; bus.mem_write_data = tbl[i].wdata;
      cycle();
      check("tbl_hash_valid", 256'(bus.hash_valid), 256'(tbl[i].exp_hv));
      check("tbl_write_count", 256'(bus.write_count), 256'(tbl[i].exp_cnt));
      if (tbl[i].chk_rd) check("tbl_read_data", 256'(bus.mem_read_data), 256'(tbl[i].exp_rd));
    end
    check("digest_value", bus.hash_out,
          256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888);

    // Partial digest with a rewrite of slot 3
    for (int i = 0; i < 7; i++) begin
      write_word(16'h0080 + 16'(i), 32'h0A0B0C00 + 32'(i));
      check("partial_no_valid", 256'(bus.hash_valid), 256'h0);
    end
    write_word(16'h0083, 32'hAAAAAAAA);
    check("rewrite_no_valid", 256'(bus.hash_valid), 256'h0);
    write_word(16'h0087, 32'h0A0B0C07);
    check("partial_valid", 256'(bus.hash_valid), 256'h1);
    check("partial_word3", 256'(bus.hash_out[159:128]), 256'hAAAAAAAA);
    check("partial_count", 256'(bus.write_count), 256'd17);
    read_word(16'h0000);
    check("partial_pulse_end", 256'(bus.hash_valid), 256'h0);

    // Preload 20 words from base 0
    idle(); bus.load_start = 1'b1; bus.load_base = 16'h0000;
    cycle();
    check("load_enter", 256'(bus.load_ready), 256'h1);
    for (int i = 1; i <= 20; i++) begin
      idle(); bus.load_valid = 1'b1; bus.load_data = 32'(i); bus.load_last = (i == 20);
      cycle();
      check("load_ready_beat", 256'(bus.load_ready), 256'(i != 20));
    end
    for (int i = 0; i < 20; i++) begin
      read_word(16'(i));
      check("preload_read", 256'(bus.mem_read_data), 256'(i + 1));
    end

    // load_start together with a write, then an ignored write in LOAD
    idle(); bus.mem_we = 1'b1; bus.mem_addr = 16'h0010; bus.mem_write_data = 32'h5;
    bus.load_start = 1'b1; bus.load_base = 16'h0040;
    cycle();
    check("same_cycle_state", 256'(bus.load_ready), 256'h1);
    check("same_cycle_count", 256'(bus.write_count), 256'd18);
    write_word(16'h0011, 32'h00000077);
    check("load_ignores_write", 256'(bus.write_count), 256'd18);
    idle(); bus.load_valid = 1'b1; bus.load_last = 1'b1; bus.load_data = 32'h99;
    cycle();
    check("load_exit", 256'(bus.load_ready), 256'h0);
    read_word(16'h0010);
    check("same_cycle_mem", 256'(bus.mem_read_data), 256'h5);
    read_word(16'h0011);
    check("ignored_write_mem", 256'(bus.mem_read_data), 256'h12);
    read_word(16'h0040);
    check("load_base_mem", 256'(bus.mem_read_data), 256'h99);

    // Reset mid-capture discards the partial mask
    do_reset();
    for (int i = 0; i < 4; i++) write_word(16'h0080 + 16'(i), 32'h100 + 32'(i));
    do_reset();
    for (int i = 4; i < 8; i++) begin
      write_word(16'h0080 + 16'(i), 32'h100 + 32'(i));
      check("reset_no_valid", 256'(bus.hash_valid), 256'h0);
    end
    read_word(16'h0000);
    check("reset_no_valid_after", 256'(bus.hash_valid), 256'h0);

    // Out-of-range write to 0x0100
    write_word(16'h0100, 32'hCAFEF00D);
`ifdef MEM_ADDR_CHECK_EN
    check("oor_addr_err", 256'(bus.addr_err), 256'h1);
    check("oor_count", 256'(bus.write_count), 256'd4);
    read_word(16'h0100);
    check("oor_read", 256'(bus.mem_read_data), 256'hDEADBEEF);
`else
    check("oor_addr_err", 256'(bus.addr_err), 256'h0);
    check("oor_count", 256'(bus.write_count), 256'd5);
    read_word(16'h0000);
    check("oor_wrap_read", 256'(bus.mem_read_data), 256'hCAFEF00D);
`endif
    idle(); bus.load_start = 1'b1; bus.load_base = 16'h00FE;
    cycle();
    check("err_cleared_by_start", 256'(bus.addr_err), 256'h0);
    idle(); bus.load_valid = 1'b1; bus.load_data = 32'hE0; cycle();
    idle(); bus.load_valid = 1'b1; bus.load_data = 32'hE1; cycle();
    idle(); bus.load_valid = 1'b1; bus.load_data = 32'hE2; bus.load_last = 1'b1; cycle();
    read_word(16'h0000);
    check("preload_wrap", 256'(bus.mem_read_data), 256'hE2);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int sel;
      idle();
      sel = $urandom_range(0, 9);
      if (sel < 4)       bus.mem_addr = 16'h0080 + 16'($urandom_range(0, 9));
      else if (sel < 8)  bus.mem_addr = 16'($urandom_range(0, 31));
      else if (sel == 8) bus.mem_addr = 16'($urandom_range(0, 65535));
      else               bus.mem_addr = ($urandom_range(0, 1) == 0) ? 16'h00FF : 16'h0100;
      bus.mem_we         = ($urandom_range(0, 2) != 0);
      bus.mem_write_data = $urandom;
      bus.load_start     = ($urandom_range(0, 24) == 0);
      bus.load_base      = ($urandom_range(0, 3) == 0) ? 16'h00FC : 16'($urandom_range(0, 31));
      bus.load_valid     = ($urandom_range(0, 2) != 0);
      bus.load_last      = ($urandom_range(0, 5) == 0);
      bus.load_data      = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/sha_mem_responder.md
SHA_MEM_RESPONDER -- requirements
Module: sha_mem_responder

Interface
REQ-001 Parameter DEPTH, 256, number of 32-bit words in the array; power of two, 16 to 4096.
REQ-002 Parameter OUTPUT_ADDR, 16'h0080, first of 8 consecutive word addresses captured as the digest.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port mem_we  input  1  initiator write enable.
REQ-006 Port mem_addr  input  16  initiator word address.
REQ-007 Port mem_write_data  input  32  initiator write data.
REQ-008 Port mem_read_data  output  32  registered read data to the initiator.
REQ-009 Port load_start  input  1  pulse: enter LOAD at load_base.
REQ-010 Port load_base  input  16  first preload word address.
REQ-011 Port load_valid / load_last / load_data  input  1/1/32  preload stream; load_last marks the final word.
REQ-012 Port load_ready  output  1  preload stream ready.
REQ-013 Port hash_out  output  256  captured digest; word 0 in bits 255:224.
REQ-014 Port hash_valid  output  1  one-cycle pulse when all 8 digest words have been captured.
REQ-015 Port write_count  output  16  saturating count of accepted initiator writes.
REQ-016 Port addr_err  output  1  sticky out-of-range flag (see Configuration).

Function
REQ-017 FSM states SHALL be SERVE and LOAD only.
- SERVE -> LOAD on load_start.
- LOAD -> SERVE on the cycle with load_valid & load_last.
- load_start in LOAD SHALL be ignored; the pointer is not reloaded.
REQ-018 load_ready SHALL be 1 exactly when the state is LOAD.
REQ-019 Preload beat (load_valid & load_ready): write load_data at load_ptr, then load_ptr+1, wrapping at DEPTH; load_ptr is taken from load_base on entry.
REQ-020 In SERVE with mem_we=0: mem_read_data <= mem[mem_addr], giving one-cycle latency.
- Data written at edge N SHALL be readable by an address presented after edge N.
REQ-021 In SERVE with mem_we=1: mem[mem_addr] <= mem_write_data; mem_read_data holds; write_count increments, saturating at 16'hFFFF.
REQ-022 In LOAD, initiator reads and writes SHALL be ignored: array unchanged, mem_read_data holds, write_count unchanged.
REQ-023 Digest capture: a SERVE write with OUTPUT_ADDR <= mem_addr <= OUTPUT_ADDR+7 SHALL store the word into slot (mem_addr-OUTPUT_ADDR) of hash_out and set that bit of an 8-bit capture mask.
- The array is written as well.
REQ-024 A rewrite of an already-captured slot SHALL overwrite that hash_out word and leave the mask unchanged.
REQ-025 When a write completes the mask (8'hFF): hash_valid SHALL be 1 for the single following cycle and the mask SHALL clear at the same edge; hash_out holds its value.
REQ-026 load_start accepted in SERVE SHALL clear the capture mask; it SHALL NOT clear hash_out.
REQ-027 load_start and an initiator write in the same SERVE cycle: the write is fully honored (array, count, capture) and the state enters LOAD.

Reset
REQ-028 While reset_n=0:
- state = SERVE, mem_read_data = 0, hash_out = 0, hash_valid = 0, write_count = 0, addr_err = 0, mask = 0, load_ptr = 0.
- Array contents are undefined.
REQ-029 Reset asserted mid-LOAD or mid-capture SHALL abort immediately; the partial mask is discarded.

Configuration
REQ-030 Macro MEM_ADDR_CHECK_EN, defined: an initiator or preload address >= DEPTH SHALL be handled as follows.
- Writes are dropped and write_count is not incremented.
- Reads return 32'hDEADBEEF.
- addr_err is set and stays set until reset or an accepted load_start.
REQ-031 Macro MEM_ADDR_CHECK_EN, undefined: all addresses SHALL use address mod DEPTH, and addr_err SHALL be tied to 0.

Verification
REQ-032 Preload: load_start with base 0, then 20 beats of data 0x01..0x14 with load_last on beat 20 -> load_ready falls after beat 20; reading addresses 0..19 returns 0x01..0x14, each one cycle after its address.
REQ-033 Digest: write 0x11111111..0x88888888 to 0x80..0x87 -> a single hash_valid pulse; hash_out = 0x11111111_22222222_..._88888888; write_count = 8.
REQ-034 Partial digest: write 0x80..0x86, rewrite 0x83 with 0xAAAAAAAA, then write 0x87 -> hash_valid only after the 0x87 write; word 3 = 0xAAAAAAAA.
REQ-035 Same-cycle events: load_start concurrent with a write of 0x5 to address 0x10 -> mem[0x10] = 0x5; state LOAD; a following initiator write to 0x11 is ignored.
REQ-036 Reset: reset_n low after 4 digest writes, then the 4 remaining writes -> no hash_valid.
REQ-037 Out of range: write to address 0x0100 with DEPTH=256 -> with the macro, addr_err=1 and a read returns 0xDEADBEEF; without it, mem[0x00] is written.
